// File: rtl/i2c_target.sv
// I2C target (responder). SCL/SDA are oversampled on clk through a
// synchronizer; START/STOP and SCL edges are detected on the synchronized
// copies. A 7-bit address is matched, written bytes are delivered on rx_*,
// read bytes are pulled from tx_*. SDA is open-drain (0 or Z); SCL is never
// stretched.
module i2c_target #(
  parameter logic [6:0] ADDR        = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_underrun,
  output logic       start,
  output logic       stop,
  output logic       selected,
  output logic       rw
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_WR_DATA  = 3'd3,
    ST_WR_ACK   = 3'd4,
    ST_RD_DATA  = 3'd5,
    ST_RD_ACK   = 3'd6,
    ST_IGNORE   = 3'd7
  } state_t;

  // synchronizer chains and previous-cycle copies
  logic [SYNC_STAGES-1:0] scl_sync_r;
  logic [SYNC_STAGES-1:0] sda_sync_r;
  logic                   scl_prev_r;
  logic                   sda_prev_r;
  logic                   scl_s;
  logic                   sda_s;

  // bus events
  logic scl_rise_s;
  logic scl_fall_s;
  logic start_det_s;
  logic stop_det_s;

  // registered state
  state_t     state_r;
  logic [2:0] bit_cnt_r;
  logic [7:0] shift_r;
  logic       ack_drv_r;
  logic       sda_oe_r;
  logic [7:0] rx_data_r;
  logic       rx_valid_r;
  logic       tx_ready_r;
  logic       tx_underrun_r;
  logic       start_r;
  logic       stop_r;
  logic       selected_r;
  logic       rw_r;

  // next-state values
  state_t     state_next_s;
  logic [2:0] bit_cnt_next_s;
  logic [7:0] shift_next_s;
  logic       ack_drv_next_s;
  logic       sda_oe_next_s;
  logic [7:0] rx_data_next_s;
  logic       rx_valid_next_s;
  logic       tx_ready_next_s;
  logic       tx_underrun_next_s;
  logic       start_next_s;
  logic       stop_next_s;
  logic       selected_next_s;
  logic       rw_next_s;

  // helpers
  logic [7:0] byte_in_s;
  logic [7:0] load_byte_s;
  logic       load_ok_s;

  assign scl_s = scl_sync_r[SYNC_STAGES-1];
  assign sda_s = sda_sync_r[SYNC_STAGES-1];

  assign scl_rise_s  = scl_s & ~scl_prev_r;
  assign scl_fall_s  = ~scl_s & scl_prev_r;
  assign start_det_s = scl_s & scl_prev_r & sda_prev_r & ~sda_s;
  assign stop_det_s  = scl_s & scl_prev_r & ~sda_prev_r & sda_s;

  // byte as it would look once the bit sampled this cycle is shifted in
  assign byte_in_s = {shift_r[6:0], sda_s};

  assign sda         = sda_oe_r ? 1'b0 : 1'bz;
  assign rx_data     = rx_data_r;
  assign rx_valid    = rx_valid_r;
  assign tx_ready    = tx_ready_r;
  assign tx_underrun = tx_underrun_r;
  assign start       = start_r;
  assign stop        = stop_r;
  assign selected    = selected_r;
  assign rw          = rw_r;

  // synchronize the bus lines; idle-high reset value avoids a false edge
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_r <= {SYNC_STAGES{1'b1}};
      sda_sync_r <= {SYNC_STAGES{1'b1}};
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl};
      sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda};
      scl_prev_r <= scl_s;
      sda_prev_r <= sda_s;
    end
  end

  // choose the next read byte: supplied data, or all-ones on underrun
  always_comb begin
    load_byte_s = 8'hFF;
    load_ok_s   = 1'b0;
    if (tx_valid) begin
      load_byte_s = tx_data;
      load_ok_s   = 1'b1;
    end else begin
      load_byte_s = 8'hFF;
      load_ok_s   = 1'b0;
    end
  end

  // next-state and output logic; START/STOP override any data activity
  always_comb begin
    state_next_s       = state_r;
    bit_cnt_next_s     = bit_cnt_r;
    shift_next_s       = shift_r;
    ack_drv_next_s     = ack_drv_r;
    sda_oe_next_s      = sda_oe_r;
    rx_data_next_s     = rx_data_r;
    rx_valid_next_s    = 1'b0;
    tx_ready_next_s    = 1'b0;
    tx_underrun_next_s = 1'b0;
    start_next_s       = 1'b0;
    stop_next_s        = 1'b0;
    selected_next_s    = selected_r;
    rw_next_s          = rw_r;

    if (start_det_s) begin
      state_next_s    = ST_ADDR;
      bit_cnt_next_s  = 3'd0;
      ack_drv_next_s  = 1'b0;
      sda_oe_next_s   = 1'b0;
      selected_next_s = 1'b0;
      start_next_s    = 1'b1;
    end else if (stop_det_s) begin
      state_next_s    = ST_IDLE;
      bit_cnt_next_s  = 3'd0;
      ack_drv_next_s  = 1'b0;
      sda_oe_next_s   = 1'b0;
      selected_next_s = 1'b0;
      stop_next_s     = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          sda_oe_next_s   = 1'b0;
          selected_next_s = 1'b0;
        end

        ST_ADDR: begin
          if (scl_rise_s) begin
            shift_next_s   = byte_in_s;
            bit_cnt_next_s = bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              // general-call (all-zero) address is never claimed
              if ((byte_in_s[7:1] == ADDR) && (byte_in_s[7:1] != 7'd0)) begin
                state_next_s   = ST_ADDR_ACK;
                rw_next_s      = byte_in_s[0];
                ack_drv_next_s = 1'b0;
              end else begin
                state_next_s = ST_IGNORE;
              end
            end else begin
              state_next_s = ST_ADDR;
            end
          end else begin
            state_next_s = ST_ADDR;
          end
        end

        ST_ADDR_ACK: begin
          if (scl_fall_s) begin
            if (!ack_drv_r) begin
              // first fall ends the address byte: pull SDA low for ACK
              ack_drv_next_s  = 1'b1;
              sda_oe_next_s   = 1'b1;
              selected_next_s = 1'b1;
            end else begin
              // second fall ends the ACK clock
              ack_drv_next_s = 1'b0;
              bit_cnt_next_s = 3'd0;
              if (rw_r) begin
                state_next_s       = ST_RD_DATA;
                shift_next_s       = load_byte_s;
                sda_oe_next_s      = ~load_byte_s[7];
                tx_ready_next_s    = load_ok_s;
                tx_underrun_next_s = ~load_ok_s;
              end else begin
                state_next_s  = ST_WR_DATA;
                sda_oe_next_s = 1'b0;
              end
            end
          end else begin
            state_next_s = ST_ADDR_ACK;
          end
        end

        ST_WR_DATA: begin
          if (scl_rise_s) begin
            shift_next_s   = byte_in_s;
            bit_cnt_next_s = bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              rx_data_next_s  = byte_in_s;
              rx_valid_next_s = 1'b1;
              state_next_s    = ST_WR_ACK;
              ack_drv_next_s  = 1'b0;
            end else begin
              state_next_s = ST_WR_DATA;
            end
          end else begin
            state_next_s = ST_WR_DATA;
          end
        end

        ST_WR_ACK: begin
          if (scl_fall_s) begin
            if (!ack_drv_r) begin
              ack_drv_next_s = 1'b1;
              sda_oe_next_s  = 1'b1;
            end else begin
              ack_drv_next_s = 1'b0;
              sda_oe_next_s  = 1'b0;
              bit_cnt_next_s = 3'd0;
              state_next_s   = ST_WR_DATA;
            end
          end else begin
            state_next_s = ST_WR_ACK;
          end
        end

        ST_RD_DATA: begin
          // MSB was put on the bus at entry; each fall presents the next bit
          if (scl_fall_s) begin
            if (bit_cnt_r == 3'd7) begin
              sda_oe_next_s  = 1'b0;
              bit_cnt_next_s = 3'd0;
              state_next_s   = ST_RD_ACK;
            end else begin
              sda_oe_next_s  = ~shift_r[6];
              shift_next_s   = {shift_r[6:0], 1'b1};
              bit_cnt_next_s = bit_cnt_r + 3'd1;
              state_next_s   = ST_RD_DATA;
            end
          end else begin
            state_next_s = ST_RD_DATA;
          end
        end

        ST_RD_ACK: begin
          if (scl_rise_s) begin
            if (sda_s) begin
              // controller NACK: transfer over for this target
              state_next_s    = ST_IGNORE;
              selected_next_s = 1'b0;
            end else begin
              state_next_s = ST_RD_ACK;
            end
          end else if (scl_fall_s) begin
            // only reachable after an ACK was sampled on the rise
            state_next_s       = ST_RD_DATA;
            bit_cnt_next_s     = 3'd0;
            shift_next_s       = load_byte_s;
            sda_oe_next_s      = ~load_byte_s[7];
            tx_ready_next_s    = load_ok_s;
            tx_underrun_next_s = ~load_ok_s;
          end else begin
            state_next_s = ST_RD_ACK;
          end
        end

        ST_IGNORE: begin
          sda_oe_next_s   = 1'b0;
          selected_next_s = 1'b0;
        end

        default: begin
          state_next_s    = ST_IDLE;
          sda_oe_next_s   = 1'b0;
          selected_next_s = 1'b0;
        end
      endcase
    end
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      bit_cnt_r     <= 3'd0;
      shift_r       <= 8'h00;
      ack_drv_r     <= 1'b0;
      sda_oe_r      <= 1'b0;
      rx_data_r     <= 8'h00;
      rx_valid_r    <= 1'b0;
      tx_ready_r    <= 1'b0;
      tx_underrun_r <= 1'b0;
      start_r       <= 1'b0;
      stop_r        <= 1'b0;
      selected_r    <= 1'b0;
      rw_r          <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      bit_cnt_r     <= bit_cnt_next_s;
      shift_r       <= shift_next_s;
      ack_drv_r     <= ack_drv_next_s;
      sda_oe_r      <= sda_oe_next_s;
      rx_data_r     <= rx_data_next_s;
      rx_valid_r    <= rx_valid_next_s;
      tx_ready_r    <= tx_ready_next_s;
      tx_underrun_r <= tx_underrun_next_s;
      start_r       <= start_next_s;
      stop_r        <= stop_next_s;
      selected_r    <= selected_next_s;
      rw_r          <= rw_next_s;
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-level I2C controller model drives the bus,
// expected acks/bytes/pulse counts come from transaction-level rules.
module tb_i2c_target;

  localparam int         Q   = 10;     // quarter SCL period in clk cycles
  localparam logic [6:0] TGT = 7'h42;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       tb_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  wire        sda_bus;
  logic [7:0] rx_data;
  logic       rx_valid, tx_ready, tx_underrun, start, stop, selected, rw;

  pullup (sda_bus);
  assign sda_bus = tb_low ? 1'b0 : 1'bz;

  i2c_target dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda_bus),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_underrun(tx_underrun), .start(start), .stop(stop),
    .selected(selected), .rw(rw)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int start_cnt = 0, stop_cnt = 0, rdy_cnt = 0, und_cnt = 0;
  int sel_cyc = 0, dut_low_cyc = 0;
  logic [7:0] rx_log[$];

  logic [7:0] wbuf[0:3];
  logic [7:0] tbuf[0:3];

  // tally DUT pulses and bus activity
  always @(negedge clk) begin
    if (start)       start_cnt <= start_cnt + 1;
    if (stop)        stop_cnt  <= stop_cnt + 1;
    if (tx_ready)    rdy_cnt   <= rdy_cnt + 1;
    if (tx_underrun) und_cnt   <= und_cnt + 1;
    if (selected)    sel_cyc   <= sel_cyc + 1;
    if (sda_bus === 1'b0 && !tb_low) dut_low_cyc <= dut_low_cyc + 1;
    if (rx_valid)    rx_log.push_back(rx_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_bit(input logic b, output logic s);
    wq(Q); tb_low = ~b;
    wq(Q); scl = 1'b1;
    wq(Q); s = sda_bus;
    wq(Q); scl = 1'b0;
  endtask

  task automatic bus_start();
    wq(Q); tb_low = 1'b0;
    wq(Q); scl = 1'b1;
    wq(Q); tb_low = 1'b1;
    wq(Q); scl = 1'b0;
  endtask

  task automatic bus_stop();
    wq(Q); tb_low = 1'b1;
    wq(Q); scl = 1'b1;
    wq(Q); tb_low = 1'b0;
    wq(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, s);
    acked = ~s;
  endtask

  task automatic read_bits(output logic [7:0] v);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      v[i] = s;
    end
  endtask

  // full write transaction; expectations from address match rule
  task automatic do_write(input logic [6:0] a, input int n);
    logic ack, hit;
    int rx0, st0, sp0, sel0, low0;
    hit  = (a == TGT);
    rx0  = rx_log.size();
    st0  = start_cnt; sp0 = stop_cnt; sel0 = sel_cyc; low0 = dut_low_cyc;
    bus_start();
    write_byte({a, 1'b0}, ack);
    check("wr_addr_ack", ack, hit);
    for (int i = 0; i < n; i++) begin
      write_byte(wbuf[i], ack);
      check("wr_data_ack", ack, hit);
    end
    bus_stop();
    wq(6);
    check("wr_rx_count", rx_log.size() - rx0, hit ? n : 0);
    if (hit) begin
      for (int i = 0; i < n; i++) check("wr_rx_byte", rx_log[rx0 + i], wbuf[i]);
    end else begin
      check("wr_ign_sel", sel_cyc - sel0, 0);
      check("wr_ign_sda", dut_low_cyc - low0, 0);
    end
    check("wr_start_cnt", start_cnt - st0, 1);
    check("wr_stop_cnt", stop_cnt - sp0, 1);
    check("wr_sel_after", selected, 1'b0);
  endtask

  // full read transaction; controller ACKs all but the last byte
  task automatic do_read(input logic [6:0] a, input int n, input logic valid);
    logic ack, hit, s;
    logic [7:0] v, exp;
    int r0, u0;
    hit = (a == TGT);
    r0 = rdy_cnt; u0 = und_cnt;
    tx_valid = valid;
    tx_data  = tbuf[0];
    bus_start();
    write_byte({a, 1'b1}, ack);
    check("rd_addr_ack", ack, hit);
    for (int i = 0; i < n; i++) begin
      read_bits(v);
      if (i < n - 1) tx_data = tbuf[i + 1];
      exp = (hit && valid) ? tbuf[i] : 8'hFF;
      check("rd_byte", v, exp);
      bus_bit((i == n - 1) ? 1'b1 : 1'b0, s);
    end
    wq(6);
    check("rd_released", sda_bus, 1'b1);
    check("rd_sel_nack", selected, 1'b0);
    bus_stop();
    wq(6);
    tx_valid = 1'b0;
    check("rd_ready_cnt", rdy_cnt - r0, (hit && valid) ? n : 0);
    check("rd_underrun_cnt", und_cnt - u0, (hit && !valid) ? n : 0);
  endtask

  initial begin
    logic ack, s;
    logic [7:0] v;
    int st0, sp0, n, pick;
    logic [6:0] a;

    // reset state
    wq(5);
    check("rst_sda", sda_bus, 1'b1);
    check("rst_selected", selected, 1'b0);
    check("rst_rw", rw, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_pulses", {rx_valid, tx_ready, tx_underrun, start, stop}, 5'b0);
    rst = 1'b0;
    wq(10);

    // write A5,3C to matching address
    wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
    do_write(TGT, 2);

    // write to non-matching address
    wbuf[0] = 8'($urandom); wbuf[1] = 8'($urandom);
    do_write(7'h43, 2);

    // read 81,7E with ACK then NACK
    tbuf[0] = 8'h81; tbuf[1] = 8'h7E;
    do_read(TGT, 2, 1'b1);

    // read with no data available
    tbuf[0] = 8'($urandom);
    do_read(TGT, 1, 1'b0);

    // repeated START: write address, then read address
    st0 = start_cnt; sp0 = stop_cnt;
    bus_start();
    write_byte({TGT, 1'b0}, ack);
    check("rs_wr_ack", ack, 1'b1);
    wq(6);
    check("rs_sel_wr", selected, 1'b1);
    check("rs_rw0", rw, 1'b0);
    tbuf[0] = 8'($urandom);
    tx_valid = 1'b1; tx_data = tbuf[0];
    bus_start();
    write_byte({TGT, 1'b1}, ack);
    check("rs_rd_ack", ack, 1'b1);
    wq(6);
    check("rs_rw1", rw, 1'b1);
    check("rs_sel_rd", selected, 1'b1);
    read_bits(v);
    bus_bit(1'b1, s);
    tx_valid = 1'b0;
    check("rs_byte", v, tbuf[0]);
    check("rs_start_cnt", start_cnt - st0, 2);
    check("rs_no_stop", stop_cnt - sp0, 0);
    bus_stop();
    wq(6);
    check("rs_stop_cnt", stop_cnt - sp0, 1);

    // reset while the target drives a write-data ACK
    wbuf[0] = 8'($urandom);
    bus_start();
    write_byte({TGT, 1'b0}, ack);
    for (int i = 7; i >= 0; i--) bus_bit(wbuf[0][i], s);
    wq(Q); tb_low = 1'b0;
    wq(Q); scl = 1'b1;
    wq(Q);
    check("ack_before_rst", sda_bus, 1'b0);
    rst = 1'b1;
    wq(1);
    check("rst_mid_sda", sda_bus, 1'b1);
    check("rst_mid_sel", selected, 1'b0);
    check("rst_mid_rx", rx_data, 8'h00);
    rst = 1'b0;
    wq(Q); scl = 1'b0;
    bus_stop();
    wq(10);
    wbuf[0] = 8'($urandom); wbuf[1] = 8'($urandom);
    do_write(TGT, 2);

    // randomized transactions
    for (int k = 0; k < 6; k++) begin
      pick = $urandom_range(0, 3);
      if (pick < 2)       a = TGT;
      else if (pick == 2) a = 7'h43;
      else                a = 7'h00;
      n = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) begin
        wbuf[i] = 8'($urandom);
        tbuf[i] = 8'($urandom);
      end
      if ($urandom_range(0, 1) == 0) do_write(a, n);
      else do_read(a, n, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
